com_fw_to_dut_mux: RTL and testbench



---
 rtl/com_fw_to_dut_mux.sv | 165 ++++++++++++++++
 tb/tb_com_fw_to_dut_mux.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/com_fw_to_dut_mux.sv
// Routes one of NUM_FW firmware blocks to the shared DUT pins.
// Outputs come from IOB registers and inputs pass through a synchroniser.
// Changing firmware inserts a guard interval. While the guard runs, every pin is
// held at OUT_IDLE and every firmware return reads zero.
module com_fw_to_dut_mux #(
    parameter int                 NUM_FW         = 4,
    parameter int                 NUM_OUT        = 10,
    parameter int                 NUM_IN         = 5,
    parameter int                 IN_SYNC_STAGES = 2,
    parameter int                 SWITCH_GUARD   = 16,
    parameter logic [NUM_OUT-1:0] OUT_IDLE       = {NUM_OUT{1'b0}},
    localparam int                SEL_W          = $clog2(NUM_FW)
) (
    input  logic                      iob_clk,
    input  logic                      reset,
    input  logic [NUM_FW-1:0]         fw_dev_id_enable,
    input  logic [NUM_FW*NUM_OUT-1:0] fw_out,
    output logic [NUM_FW*NUM_IN-1:0]  fw_in,
    output logic [NUM_OUT-1:0]        dut_out,
    input  logic [NUM_IN-1:0]         dut_in,
    output logic [SEL_W-1:0]          sel_active,
    output logic                      sel_valid,
    output logic                      switch_busy,
    output logic                      sel_error,
    output logic [15:0]               switch_count
);

    localparam int GCNT_W = (SWITCH_GUARD > 1) ? $clog2(SWITCH_GUARD) : 1;
    localparam logic [GCNT_W-1:0] GUARD_LOAD = GCNT_W'(SWITCH_GUARD - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_GUARD, ST_ACTIVE} state_t;

    state_t                   state_reg, state_next;
    logic [SEL_W-1:0]         cand_reg, cand_next;
    logic [GCNT_W-1:0]        guard_cnt_reg, guard_cnt_next;
    logic [SEL_W-1:0]         sel_active_reg, sel_active_next;
    logic [15:0]              switch_count_reg, switch_count_next;
    logic [NUM_OUT-1:0]       dut_out_reg;
    logic [NUM_FW*NUM_IN-1:0] fw_in_reg;
    logic                     sel_error_reg;
    logic [NUM_IN-1:0]        sync_reg [IN_SYNC_STAGES];

    logic                     sel_onehot;
    logic                     sel_multi;
    logic [SEL_W-1:0]         cand;
    logic [NUM_IN-1:0]        in_s;

    // Classify the select as onehot or multi-bit, and find the index of the set bit
    always_comb begin
        sel_multi  = (fw_dev_id_enable & (fw_dev_id_enable - 1'b1)) != '0;
        sel_onehot = (fw_dev_id_enable != '0) && !sel_multi;
        cand       = '0;
        for (int i = 0; i < NUM_FW; i++) begin
            if (fw_dev_id_enable[i]) begin
                cand = SEL_W'(i);
            end
        end
    end

    // Next-state logic: a non-onehot select drops to IDLE; any change of firmware restarts the guard
    always_comb begin
        state_next        = state_reg;
        cand_next         = cand_reg;
        guard_cnt_next    = guard_cnt_reg;
        sel_active_next   = sel_active_reg;
        switch_count_next = switch_count_reg;
        if (!sel_onehot) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_next     = ST_GUARD;
                    cand_next      = cand;
                    guard_cnt_next = GUARD_LOAD;
                end
                ST_GUARD: begin
                    if (cand != cand_reg) begin
                        cand_next      = cand;
                        guard_cnt_next = GUARD_LOAD;
                    end else if (guard_cnt_reg == '0) begin
                        state_next      = ST_ACTIVE;
                        sel_active_next = cand_reg;
                        if (switch_count_reg != 16'hFFFF) begin
                            switch_count_next = switch_count_reg + 16'd1;
                        end
                    end else begin
                        guard_cnt_next = guard_cnt_reg - GCNT_W'(1);
                    end
                end
                ST_ACTIVE: begin
                    if (cand != sel_active_reg) begin
                        state_next     = ST_GUARD;
                        cand_next      = cand;
                        guard_cnt_next = GUARD_LOAD;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Control state, the error flag and the selected firmware's output pins
    always_ff @(posedge iob_clk) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            cand_reg         <= '0;
            guard_cnt_reg    <= '0;
            sel_active_reg   <= '0;
            switch_count_reg <= '0;
            sel_error_reg    <= 1'b0;
            dut_out_reg      <= OUT_IDLE;
        end else begin
            state_reg        <= state_next;
            cand_reg         <= cand_next;
            guard_cnt_reg    <= guard_cnt_next;
            sel_active_reg   <= sel_active_next;
            switch_count_reg <= switch_count_next;
            sel_error_reg    <= sel_multi;
            if (state_reg == ST_ACTIVE) begin
                dut_out_reg <= fw_out[sel_active_reg*NUM_OUT +: NUM_OUT];
            end else begin
                dut_out_reg <= OUT_IDLE;
            end
        end
    end

    // The input synchroniser runs in every state, so in_s is already settled when ACTIVE is entered
    genvar gi;
    generate
        for (gi = 0; gi < IN_SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge iob_clk) begin
                if (reset) begin
                    sync_reg[gi] <= '0;
                end else if (gi == 0) begin
                    sync_reg[gi] <= dut_in;
                end else begin
                    sync_reg[gi] <= sync_reg[(gi > 0) ? gi - 1 : 0];
                end
            end
        end

        // Each firmware return slice sees the DUT pins only while that firmware is routed
        for (gi = 0; gi < NUM_FW; gi++) begin : g_fw_in
            always_ff @(posedge iob_clk) begin
                if (reset) begin
                    fw_in_reg[gi*NUM_IN +: NUM_IN] <= '0;
                end else if (state_reg == ST_ACTIVE && sel_active_reg == SEL_W'(gi)) begin
                    fw_in_reg[gi*NUM_IN +: NUM_IN] <= in_s;
                end else begin
                    fw_in_reg[gi*NUM_IN +: NUM_IN] <= '0;
                end
            end
        end
    endgenerate

    assign in_s         = sync_reg[IN_SYNC_STAGES-1];
    assign dut_out      = dut_out_reg;
    assign fw_in        = fw_in_reg;
    assign sel_active   = sel_active_reg;
    assign sel_valid    = (state_reg == ST_ACTIVE);
    assign switch_busy  = (state_reg == ST_GUARD);
    assign sel_error    = sel_error_reg;
    assign switch_count = switch_count_reg;

endmodule

// File: tb/tb_com_fw_to_dut_mux.sv
// Scoreboard bench for com_fw_to_dut_mux with default parameters.
// Expectations are tagged with the edge number at which they must hold.
module tb_com_fw_to_dut_mux;

    localparam int NUM_FW  = 4;
    localparam int NUM_OUT = 10;
    localparam int NUM_IN  = 5;
    localparam int GUARD   = 16;

    localparam int ID_DUT_OUT = 0;
    localparam int ID_FW_IN   = 1;
    localparam int ID_SEL     = 2;
    localparam int ID_VALID   = 3;
    localparam int ID_BUSY    = 4;
    localparam int ID_ERROR   = 5;
    localparam int ID_COUNT   = 6;

    logic                      iob_clk = 1'b0;
    logic                      reset;
    logic [NUM_FW-1:0]         fw_dev_id_enable;
    logic [NUM_FW*NUM_OUT-1:0] fw_out;
    logic [NUM_FW*NUM_IN-1:0]  fw_in;
    logic [NUM_OUT-1:0]        dut_out;
    logic [NUM_IN-1:0]         dut_in;
    logic [1:0]                sel_active;
    logic                      sel_valid;
    logic                      switch_busy;
    logic                      sel_error;
    logic [15:0]               switch_count;

    com_fw_to_dut_mux dut (
        .iob_clk          (iob_clk),
        .reset            (reset),
        .fw_dev_id_enable (fw_dev_id_enable),
        .fw_out           (fw_out),
        .fw_in            (fw_in),
        .dut_out          (dut_out),
        .dut_in           (dut_in),
        .sel_active       (sel_active),
        .sel_valid        (sel_valid),
        .switch_busy      (switch_busy),
        .sel_error        (sel_error),
        .switch_count     (switch_count)
    );

    always #5 iob_clk = ~iob_clk;

    typedef struct {
        string       tag;
        int          due;
        int          id;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb[$];
    int          tests_run    = 0;
    int          tests_failed = 0;
    int          cyc          = 0;
    logic [15:0] cnt_model    = 16'd0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s @edge %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [31:0] obs_of(input int id);
        case (id)
            ID_DUT_OUT: return 32'(dut_out);
            ID_FW_IN:   return 32'(fw_in);
            ID_SEL:     return 32'(sel_active);
            ID_VALID:   return 32'(sel_valid);
            ID_BUSY:    return 32'(switch_busy);
            ID_ERROR:   return 32'(sel_error);
            default:    return 32'(switch_count);
        endcase
    endfunction

    task automatic push(input string tag, input int due, input int id, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.due = due;
        e.id  = id;
        e.exp = exp;
        sb.push_back(e);
    endtask

    // Compare and retire every expectation that falls due at this edge
    task automatic score();
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                check_val(sb[i].tag, obs_of(sb[i].id), sb[i].exp);
                sb.delete(i);
            end
        end
    endtask

    // One clock: the edge counter advances at the posedge, outputs are sampled at the negedge
    task automatic tick();
        @(posedge iob_clk);
        cyc++;
        @(negedge iob_clk);
        score();
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    // Expectations for a switch to firmware k whose select change is seen at edge e
    task automatic expect_switch(input int e, input int k);
        logic [9:0]  fw_v;
        logic [19:0] ret_v;
        fw_v  = fw_out[k*NUM_OUT +: NUM_OUT];
        ret_v = 20'(dut_in) << (k * NUM_IN);
        if (cnt_model != 16'hFFFF) cnt_model = cnt_model + 16'd1;
        $display("[TB] switch to fw %0d seen at edge %0d, expect active at %0d", k, e, e + GUARD);
        for (int t = e; t < e + GUARD; t++) push("busy_in_guard", t, ID_BUSY, 32'd1);
        for (int t = e + 1; t <= e + GUARD; t++) begin
            push("dut_out_idle", t, ID_DUT_OUT, 32'd0);
            push("fw_in_idle", t, ID_FW_IN, 32'd0);
        end
        push("valid_low_guard", e + GUARD - 1, ID_VALID, 32'd0);
        push("busy_end", e + GUARD, ID_BUSY, 32'd0);
        push("valid_rise", e + GUARD, ID_VALID, 32'd1);
        push("sel_active", e + GUARD, ID_SEL, 32'(k));
        push("switch_count", e + GUARD, ID_COUNT, 32'(cnt_model));
        push("dut_out_new_fw", e + GUARD + 1, ID_DUT_OUT, 32'(fw_v));
        push("fw_in_new_fw", e + GUARD + 1, ID_FW_IN, 32'(ret_v));
    endtask

    initial begin
        int e;
        int f;
        int c;
        fw_out           = {10'h344, 10'h233, 10'h122, 10'h011};
        dut_in           = 5'h0A;
        fw_dev_id_enable = 4'b0001;
        reset            = 1'b1;

        // Reset with a onehot select already present
        tick();
        tick();
        push("rst_dut_out", cyc + 1, ID_DUT_OUT, 32'd0);
        push("rst_fw_in", cyc + 1, ID_FW_IN, 32'd0);
        push("rst_sel", cyc + 1, ID_SEL, 32'd0);
        push("rst_valid", cyc + 1, ID_VALID, 32'd0);
        push("rst_busy", cyc + 1, ID_BUSY, 32'd0);
        push("rst_error", cyc + 1, ID_ERROR, 32'd0);
        push("rst_count", cyc + 1, ID_COUNT, 32'd0);
        tick();
        reset = 1'b0;
        e = cyc + 1;
        expect_switch(e, 0);
        run_to(e + GUARD + 1);

        // Routing on firmware 2
        fw_dev_id_enable = 4'b0100;
        e = cyc + 1;
        expect_switch(e, 2);
        run_to(e + GUARD + 1);
        fw_out[29:20] = 10'h2A5;
        dut_in        = 5'h13;
        c = cyc;
        push("route_dut_out", c + 1, ID_DUT_OUT, 32'h2A5);
        push("route_fw_in_old", c + 2, ID_FW_IN, 32'(20'h0A << 10));
        push("route_fw_in_new", c + 3, ID_FW_IN, 32'(20'h13 << 10));
        run_to(c + 3);

        // Switch guard: firmware 0 then firmware 3
        fw_dev_id_enable = 4'b0001;
        e = cyc + 1;
        expect_switch(e, 0);
        run_to(e + GUARD + 1);
        fw_dev_id_enable = 4'b1000;
        e = cyc + 1;
        push("last_old_fw", e, ID_DUT_OUT, 32'h011);
        expect_switch(e, 3);
        run_to(e + GUARD + 1);

        // Guard restart: toward firmware 1, then firmware 2 when guard_cnt is 5
        fw_dev_id_enable = 4'b0010;
        e = cyc + 1;
        $display("[TB] select fw 1 seen at edge %0d", e);
        f = e + 11;
        for (int t = e; t < f; t++) push("busy_first_guard", t, ID_BUSY, 32'd1);
        for (int t = e + 1; t <= f; t++) push("no_fw1_on_pins", t, ID_DUT_OUT, 32'd0);
        run_to(f - 1);
        fw_dev_id_enable = 4'b0100;
        expect_switch(f, 2);
        run_to(f + GUARD + 1);

        // Invalid select: multi-bit, then zero
        fw_dev_id_enable = 4'b0110;
        e = cyc + 1;
        $display("[TB] multi-bit select seen at edge %0d", e);
        for (int t = e; t <= e + 2; t++) push("err_multi", t, ID_ERROR, 32'd1);
        push("multi_valid", e, ID_VALID, 32'd0);
        push("multi_busy", e, ID_BUSY, 32'd0);
        push("multi_last_fw", e, ID_DUT_OUT, 32'h2A5);
        push("multi_dut_out", e + 1, ID_DUT_OUT, 32'd0);
        push("multi_dut_out2", e + 2, ID_DUT_OUT, 32'd0);
        push("multi_fw_in", e + 1, ID_FW_IN, 32'd0);
        push("multi_count", e + 2, ID_COUNT, 32'(cnt_model));
        push("multi_sel_hold", e + 2, ID_SEL, 32'd2);
        run_to(e + 2);
        fw_dev_id_enable = 4'b0000;
        e = cyc + 1;
        $display("[TB] zero select seen at edge %0d", e);
        push("err_zero", e, ID_ERROR, 32'd0);
        push("err_zero2", e + 1, ID_ERROR, 32'd0);
        push("zero_valid", e + 1, ID_VALID, 32'd0);
        push("zero_busy", e + 1, ID_BUSY, 32'd0);
        push("zero_dut_out", e + 1, ID_DUT_OUT, 32'd0);
        push("zero_count", e + 1, ID_COUNT, 32'(cnt_model));
        run_to(e + 1);

        // Saturation: preload the counter, then three more switches
        force dut.switch_count_reg = 16'hFFFE;
        #1;
        release dut.switch_count_reg;
        cnt_model = 16'hFFFE;
        $display("[TB] switch_count preloaded to fffe at edge %0d", cyc);
        push("count_preload", cyc + 1, ID_COUNT, 32'hFFFE);
        tick();
        fw_dev_id_enable = 4'b0001;
        e = cyc + 1;
        expect_switch(e, 0);
        run_to(e + GUARD + 1);
        fw_dev_id_enable = 4'b0010;
        e = cyc + 1;
        expect_switch(e, 1);
        run_to(e + GUARD + 1);
        fw_dev_id_enable = 4'b1000;
        e = cyc + 1;
        expect_switch(e, 3);
        run_to(e + GUARD + 1);
        push("count_saturated", cyc + 2, ID_COUNT, 32'hFFFF);
        run_to(cyc + 2);

        foreach (sb[i]) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s: expectation for edge %0d never checked, expected %h", sb[i].tag, sb[i].due, sb[i].exp);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
